// File: rtl/seq_signed_divider_if.sv
// ============================================================================
// Module  : seq_signed_divider_if
// Brief   : start/done handshake and operand/result bundle for the divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seq_signed_divider_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] dividend_h;
  logic [N-1:0] dividend_l;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, dividend_h, dividend_l, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend_h, dividend_l, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

`default_nettype wire

// File: rtl/seq_signed_divider.sv
// ============================================================================
// Module  : seq_signed_divider
// Brief   : sequential signed restoring divider, 2N/N -> N quotient, N remainder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_signed_divider #(
  parameter int N = 8
) (
  input  wire logic           clk,
  input  wire logic           clear,
  seq_signed_divider_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] c_cnt_init  = CW'(N);
  localparam logic [N-1:0]  c_q_max_pos = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  c_q_max_neg = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DIV  = 3'd2,
    S_SIGN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state, w_state_next;

  logic [2*N-1:0] r_dvd;
  logic [N-1:0]   r_dvs;
  logic [N:0]     r_dvs_mag;
  logic [N:0]     r_rem;
  logic [N-1:0]   r_qb;
  logic [CW-1:0]  r_cnt;
  logic           r_sign_q;
  logic           r_sign_r;
  logic [N-1:0]   r_quotient;
  logic [N-1:0]   r_remainder;
  logic           r_div_by_zero;
  logic           r_overflow;

  // Magnitudes carry one extra bit so the most negative values stay exact.
  logic [2*N:0] w_dvd_ext, w_dvd_mag;
  logic [N:0]   w_dvs_ext, w_dvs_mag;
  logic         w_dvs_zero, w_pre_ovf;

  assign w_dvd_ext  = {r_dvd[2*N-1], r_dvd};
  assign w_dvd_mag  = r_dvd[2*N-1] ? -w_dvd_ext : w_dvd_ext;
  assign w_dvs_ext  = {r_dvs[N-1], r_dvs};
  assign w_dvs_mag  = r_dvs[N-1] ? -w_dvs_ext : w_dvs_ext;
  assign w_dvs_zero = (r_dvs == '0);
  assign w_pre_ovf  = (w_dvd_mag[2*N:N] >= w_dvs_mag);

  logic [N+1:0] w_shift, w_trial;
  logic         w_trial_neg;

  assign w_shift     = {r_rem, r_qb[N-1]};
  assign w_trial     = w_shift - {1'b0, r_dvs_mag};
  assign w_trial_neg = w_trial[N+1];

  logic [N-1:0] w_q_signed, w_r_signed;
  logic         w_q_ovf;

  assign w_q_signed = r_sign_q ? -r_qb : r_qb;
  assign w_r_signed = r_sign_r ? -r_rem[N-1:0] : r_rem[N-1:0];
  assign w_q_ovf    = r_sign_q ? (r_qb > c_q_max_neg) : (r_qb > c_q_max_pos);

  always_ff @(posedge clk) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_state_next = S_LOAD;
      S_LOAD: w_state_next = (w_dvs_zero || w_pre_ovf) ? S_DONE : S_DIV;
      S_DIV:  if (r_cnt == CW'(1)) w_state_next = S_SIGN;
      S_SIGN: w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_dvs_mag     <= '0;
      r_rem         <= '0;
      r_qb          <= '0;
      r_cnt         <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dvd <= {bus.dividend_h, bus.dividend_l};
            r_dvs <= bus.divisor;
          end
        end
        S_LOAD: begin
          r_div_by_zero <= w_dvs_zero;
          r_overflow    <= !w_dvs_zero && w_pre_ovf;
          r_sign_q      <= r_dvd[2*N-1] ^ r_dvs[N-1];
          r_sign_r      <= r_dvd[2*N-1];
          r_dvs_mag     <= w_dvs_mag;
          r_rem         <= w_dvd_mag[2*N:N];
          r_qb          <= w_dvd_mag[N-1:0];
          r_cnt         <= c_cnt_init;
          if (w_dvs_zero || w_pre_ovf) begin
            r_quotient  <= '0;
            r_remainder <= '0;
          end
        end
        S_DIV: begin
          // Partial remainder stays below |divisor|, so the top bit never overflows.
          r_rem <= w_trial_neg ? w_shift[N:0] : w_trial[N:0];
          r_qb  <= {r_qb[N-2:0], ~w_trial_neg};
          r_cnt <= r_cnt - CW'(1);
        end
        S_SIGN: begin
          r_quotient  <= w_q_signed;
          r_remainder <= w_r_signed;
          r_overflow  <= w_q_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.overflow    = r_overflow;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
// ============================================================================
// Module  : tb_seq_signed_divider
// Brief   : directed and randomized checks of seq_signed_divider against an
//           arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_signed_divider;

  logic clk = 1'b0;
  logic clear;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seq_signed_divider_if #(.N(8)) bus ();

  seq_signed_divider #(.N(8)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division truncates toward zero, remainder follows dividend.
  task automatic model(input int dd, input int dv, output int lat, output int q,
                       output int r, output int dbz, output int ovf, output bit chk_qr);
    int ad, av;
    dbz = 0; ovf = 0; q = 0; r = 0; chk_qr = 1;
    if (dv == 0) begin
      dbz = 1; lat = 2;
    end else begin
      ad = (dd < 0) ? -dd : dd;
      av = (dv < 0) ? -dv : dv;
      if ((ad >> 8) >= av) begin
        ovf = 1; lat = 2;
      end else begin
        lat = 11;
        q = dd / dv;
        r = dd % dv;
        if (q > 127 || q < -128) begin
          ovf = 1; chk_qr = 0;
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input int dd, input int dv,
                        input bit hold, input int chg_cycle);
    int lat, q, r, dbz, ovf, first_done, done_cnt, busy_bad, last_k;
    bit chk_qr;
    logic [15:0] dbits;
    logic [7:0]  qo, ro;
    int dz, ov;
    model(dd, dv, lat, q, r, dbz, ovf, chk_qr);
    dbits = dd[15:0];
    @(negedge clk);
    bus.start      = 1'b1;
    bus.dividend_h = dbits[15:8];
    bus.dividend_l = dbits[7:0];
    bus.divisor    = dv[7:0];
    @(posedge clk);
    first_done = -1; done_cnt = 0; busy_bad = 0;
    qo = '0; ro = '0; dz = 0; ov = 0;
    last_k = hold ? (2 * lat + 2) : (lat + 1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = k;
          qo = bus.quotient; ro = bus.remainder;
          dz = int'(bus.div_by_zero); ov = int'(bus.overflow);
        end
      end
      if (k <= lat && !bus.busy) busy_bad++;
      if (k == lat + 1 && bus.busy) busy_bad++;
      if (!hold && k == 1) bus.start = 1'b0;
      if (hold && k == lat + 2) bus.start = 1'b0;
      if (k == chg_cycle) begin
        bus.dividend_h = 8'($urandom); bus.dividend_l = 8'($urandom);
        bus.divisor = 8'($urandom);
      end
      if (k >= last_k) break;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, first_done, lat);
    check({tag, " done_count"}, done_cnt, hold ? 2 : 1);
    check({tag, " busy"}, busy_bad, 0);
    check({tag, " div_by_zero"}, dz, dbz);
    check({tag, " overflow"}, ov, ovf);
    if (chk_qr) begin
      check({tag, " quotient"}, int'($signed(qo)), q);
      check({tag, " remainder"}, int'($signed(ro)), r);
    end
  endtask

  initial begin
    int dv, lim, dd;
    bus.start = 1'b0; bus.dividend_h = '0; bus.dividend_l = '0; bus.divisor = '0;
    clear = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset q", int'(bus.quotient), 0);
    check("reset r", int'(bus.remainder), 0);
    check("reset flags", int'({bus.div_by_zero, bus.overflow}), 0);
    clear = 1'b0;

    run_op("100/7", 100, 7, 0, 0);
    run_op("-100/7", -100, 7, 0, 0);
    run_op("100/-7", 100, -7, 0, 0);
    run_op("-100/-7", -100, -7, 0, 0);
    run_op("-128/1", -128, 1, 0, 0);
    run_op("0/-5", 0, -5, 0, 0);
    run_op("127/-128", 127, -128, 0, 0);
    run_op("-32640/-128", -32640, -128, 0, 0);
    run_op("1234/0", 1234, 0, 0, 0);
    run_op("300/1", 300, 1, 0, 0);
    run_op("200/1", 200, 1, 0, 0);
    run_op("-32768/-128", -32768, -128, 0, 0);
    run_op("hold 77/3", 77, 3, 1, 0);
    run_op("chg -999/13", -999, 13, 0, 5);

    // Abort mid-division: everything returns to zero and no done appears.
    run_op("pre-clear 1000/-9", 1000, -9, 0, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend_h = 8'h03; bus.dividend_l = 8'hE8; bus.divisor = 8'd7;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 5) clear = 1'b1;
    end
    @(negedge clk);
    clear = 1'b0;
    check("clear busy", int'(bus.busy), 0);
    check("clear q", int'(bus.quotient), 0);
    check("clear r", int'(bus.remainder), 0);
    check("clear flags", int'({bus.div_by_zero, bus.overflow, bus.done}), 0);
    begin
      int dn = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        dn += int'(bus.done);
      end
      check("clear no done", dn, 0);
    end
    run_op("50/5", 50, 5, 0, 0);

    for (int i = 0; i < 24; i++) begin
      dv = int'($signed(8'($urandom)));
      if (i % 6 == 5) begin
        dd = int'($signed(16'($urandom)));
      end else begin
        if (dv == 0) dv = 1;
        lim = 127 * ((dv < 0) ? -dv : dv);
        dd = int'($urandom_range(2 * lim)) - lim;
      end
      run_op($sformatf("rand%0d %0d/%0d", i, dd, dv), dd, dv, 0, (i % 4 == 0) ? 4 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
